// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI-style slave front end for a small command/address RAM.
//
// A frame starts on the first posedge that sees SS_n low (E0). The next edge
// (E1) captures the command bit that also selects the sub-state, and edges
// E2..E10 shift in the remaining nine bits MSB first. A completed 10-bit word
// is presented on rx_data with a one-cycle rx_valid strobe; command bits
// [9:8] are passed through untouched for the RAM to interpret.
//
// A read is two frames: a READ_ADD frame (sets rd_addr_seen) followed by a
// READ_DATA frame (clears it). After the READ_DATA word the block waits up to
// TX_TIMEOUT cycles for tx_valid, then serialises tx_data on MISO MSB first.
// SS_n high in any active state aborts the frame on the next edge.
//
// Ports
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   SS_n      in   slave select, active low
//   MOSI      in   serial data in, MSB first
//   MISO      out  serial data out, registered, 0 when not shifting
//   rx_data   out  [9:8] command, [7:0] address/data
//   rx_valid  out  one-cycle strobe qualifying rx_data
//   tx_data   in   read data from RAM
//   tx_valid  in   qualifies tx_data while a read is waiting

module spi_slave_if #(
  parameter int TX_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // Sub-phase of READ_DATA once its word has been delivered.
  typedef enum logic [1:0] {
    TX_OFF   = 2'd0,
    TX_WAIT  = 2'd1,
    TX_SHIFT = 2'd2
  } txph_e;

  state_e          state_q, state_d;
  txph_e           txph_q, txph_d;
  logic [3:0]      cnt_q, cnt_d;       // rx bit count, reused for tx bit count
  logic [9:0]      sh_q, sh_d;         // rx shift register
  logic [9:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_seen_q, rd_seen_d;
  logic            done_q, done_d;     // word complete, ignore MOSI until SS_n
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      txsh_q, txsh_d;
  logic            miso_q, miso_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      txph_q     <= TX_OFF;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      done_q     <= 1'b0;
      tmr_q      <= '0;
      txsh_q     <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      txph_q     <= txph_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_seen_q  <= rd_seen_d;
      done_q     <= done_d;
      tmr_q      <= tmr_d;
      txsh_q     <= txsh_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    txph_d     = txph_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    done_d     = done_q;
    tmr_d      = tmr_q;
    txsh_d     = txsh_q;
    miso_d     = 1'b0;

    if (state_q == IDLE) begin
      cnt_d  = '0;
      done_d = 1'b0;
      txph_d = TX_OFF;
      if (!SS_n) state_d = CHK_CMD;
    end else if (SS_n) begin
      // Abort: even on E10 no word is delivered; rd_addr_seen untouched.
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      txph_d  = TX_OFF;
    end else begin
      case (state_q)
        CHK_CMD: begin
          sh_d  = {9'd0, MOSI};
          cnt_d = '0;
          if (!MOSI)          state_d = WRITE;
          else if (!rd_seen_q) state_d = READ_ADD;
          else                state_d = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!done_q) begin
            sh_d = {sh_q[8:0], MOSI};
            if (cnt_q == 4'd8) begin
              rx_data_d  = {sh_q[8:0], MOSI};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
              cnt_d      = '0;
              if (state_q == READ_ADD) rd_seen_d = 1'b1;
              if (state_q == READ_DATA) begin
                rd_seen_d = 1'b0;
                txph_d    = TX_WAIT;
                tmr_d     = '0;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (state_q == READ_DATA) begin
            case (txph_q)
              TX_WAIT: begin
                if (tx_valid) begin
                  // MSB goes out straight away; the rest follow from txsh.
                  miso_d = tx_data[7];
                  txsh_d = {tx_data[6:0], 1'b0};
                  cnt_d  = '0;
                  txph_d = TX_SHIFT;
                end else if (tmr_q == TMR_LAST) begin
                  txph_d = TX_OFF;
                end else begin
                  tmr_d = tmr_q + TW'(1);
                end
              end
              TX_SHIFT: begin
                if (cnt_q != 4'd7) begin
                  miso_d = txsh_q[7];
                  txsh_d = {txsh_q[6:0], 1'b0};
                  cnt_d  = cnt_q + 4'd1;
                end else begin
                  txph_d = TX_OFF;
                  cnt_d  = '0;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 SHALL expose parameter TX_TIMEOUT, default 15, max clk cycles to wait for tx_valid after a read-data request.
REQ-002 SHALL have ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial in, MSB first, sampled on posedge clk.
- MISO  output  1  serial out, registered.
- rx_data  output  10  assembled word to RAM: [9:8] command, [7:0] address/data.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  8  read data from RAM.
- tx_valid  input  1  qualifies tx_data.

Function
REQ-003 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, plus an internal flag rd_addr_seen.
REQ-004 IDLE -> CHK_CMD SHALL occur on the posedge where SS_n=0 (edge E0); IDLE otherwise holds.
REQ-005 CHK_CMD SHALL sample MOSI as rx_data bit 9 at edge E1, then transition:
- MOSI=0 -> WRITE.
- MOSI=1 and rd_addr_seen=0 -> READ_ADD.
- MOSI=1 and rd_addr_seen=1 -> READ_DATA.
REQ-006 WRITE, READ_ADD and READ_DATA SHALL shift MOSI into bits 8..0, MSB first, on edges E2..E10 using a 4-bit counter.
REQ-007 rx_valid SHALL be 1 for exactly the cycle after E10, with the full 10-bit word on rx_data; rx_data SHALL hold its value until the next completed word.
REQ-008 The block SHALL NOT decode bits [9:8]; command semantics belong to the RAM.
REQ-009 READ_ADD completion (the rx_valid cycle) SHALL set rd_addr_seen; READ_DATA completion SHALL clear it.
REQ-010 After rx_valid in WRITE/READ_ADD, the FSM SHALL stay in its state, ignoring MOSI, until SS_n=1.
REQ-011 After rx_valid in READ_DATA, the block SHALL wait for tx_valid=1. On the first posedge sampling it, tx_data SHALL load an 8-bit shift register.
REQ-012 MISO SHALL present tx_data[7..0], one bit per cycle, starting the cycle after capture, for 8 cycles; MISO SHALL be 0 at all other times.
REQ-013 tx_valid SHALL be ignored outside the READ_DATA wait window and during shift-out.
REQ-014 If tx_valid is not seen within TX_TIMEOUT cycles after rx_valid, the block SHALL stop waiting and keep MISO=0 until SS_n=1.
REQ-015 SS_n=1 sampled in any non-IDLE state SHALL force IDLE next cycle and abort any transfer: no rx_valid, MISO=0 next cycle, bit counter cleared.
REQ-016 On abort, rd_addr_seen SHALL be unchanged, except that it remains cleared if the READ_DATA rx_valid has already occurred.
REQ-017 SS_n=1 on the same edge as the last data bit (E10) SHALL count as an abort; no rx_valid is produced.

Reset
REQ-018 rst=1 at a posedge SHALL force, next cycle: state IDLE, MISO=0, rx_valid=0, rx_data=0, rd_addr_seen=0, counters and shift register 0.
REQ-019 Reset SHALL take priority over every other input, including mid-transfer; no rx_valid or MISO activity follows a reset asserted mid-transfer.

Verification
REQ-020 Write: SS_n low, MOSI 0,0,1,0,1,0,1,0,1,0 -> rx_data=0x0AA and rx_valid high for one cycle after E10; MISO stays 0.
REQ-021 Read sequence: frame 10_00000101, SS_n high, then frame 11_xxxxxxxx -> first frame yields rx_data=0x205 via READ_ADD. Second frame enters READ_DATA and yields rx_data[9:8]=11. With tx_valid driven one cycle later with tx_data=0xC3, MISO shows 1,1,0,0,0,0,1,1 on the following 8 cycles, then 0.
REQ-022 Abort: SS_n rises after 5 data bits of a WRITE frame -> IDLE next cycle, no rx_valid; the next full frame 01_11110000 yields rx_data=0x1F0.
REQ-023 Timeout: complete a READ_DATA frame and never assert tx_valid -> after 15 cycles MISO stays 0 and rd_addr_seen=0. The next command-1 frame enters READ_ADD.
REQ-024 Reset mid-frame: rst pulsed after E4 of a READ_ADD frame -> all outputs 0 next cycle, rd_addr_seen=0, no rx_valid.
REQ-025 Bench SHALL check rx_valid is never high for two consecutive cycles, and MISO=0 whenever SS_n=1.
